fpmul_stream_unit: RTL
======================

Name: fpmul_stream_unit

Overview:
Parametrised streaming wrapper around the fixed-latency pipelined FP multiplier core (FPmul, IEEE-754 single, no stall/enable).
- Accepts one operand pair per cycle over valid/ready, tags each operation, and tracks it through the core with a shadow valid/tag pipe.
- Captures results into a credit-protected output FIFO, so downstream backpressure never drops or corrupts a result.
- Sits between the operand sequencer and the result checker/monitor.

Parameters:
LAT, 5, core latency in cycles from operand sample edge to FP_Z valid; must equal the instantiated core's pipeline depth.
FIFO_DEPTH, 8, result FIFO entries; >=1; full throughput requires FIFO_DEPTH >= LAT+1.
TAG_W, 4, width of the user tag carried alongside each operation.
DATA_W, 32, operand/result width; fixed to 32 for FPmul.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous drop of all in-flight and buffered operations.
in_valid  in  1  operand pair valid.
in_ready  out  1  unit can accept this cycle.
in_a  in  DATA_W  operand A (IEEE-754 single).
in_b  in  DATA_W  operand B.
in_tag  in  TAG_W  user tag, returned with the result.
out_valid  out  1  result available at FIFO head.
out_ready  in  1  consumer takes the result.
out_data  out  DATA_W  product A*B as computed by the core.
out_tag  out  TAG_W  tag of the head result.
occupancy  out  $clog2(FIFO_DEPTH+1)  outstanding ops (in flight + buffered).
overflow  out  1  sticky error: core result arrived with FIFO full.

Behaviour:
- Reset (rst_n=0, async): valid pipe cleared, FIFO pointers/count=0, outstanding=0, overflow=0. Outputs in_ready=0, out_valid=0, out_data=0, out_tag=0, occupancy=0. in_ready rises on the first clk edge after rst_n deasserts.
- Accept: accept = in_valid && in_ready.
  - in_a/in_b are driven straight into the core.
  - {1, in_tag} enters stage 0 of a LAT-deep shadow pipe.
  - The pipe advances every cycle, with no stall.
- Credit rule: in_ready = (outstanding < FIFO_DEPTH) && !flush, with outstanding registered.
  - outstanding_next = outstanding + accept - pop, where pop = out_valid && out_ready.
  - Simultaneous accept and pop leaves outstanding unchanged.
  - occupancy = outstanding.
- Capture: when the shadow pipe's last stage is valid, core FP_Z and the tag are written to the FIFO on that edge.
  - Latency from the accept edge to out_valid high is LAT+1 cycles.
  - Results leave in accept order.
- Output: out_valid = FIFO not empty. out_data and out_tag come from the head entry and are forced to 0 when empty. Write and pop in the same cycle are both honoured.
- Holding: while out_valid=1 && out_ready=0, out_data and out_tag hold stable.
- Overflow: if a capture coincides with FIFO full and no pop, the result is dropped and overflow is set, sticky until reset. The credit rule makes this unreachable; it is an assertion target.
- Flush (sync, priority over accept/pop): the clocked edge clears the shadow pipe valids, FIFO count and outstanding. Core data already in flight is ignored. in_ready=0 during the flush cycle. overflow is not cleared.
- Reset mid-operation: all in-flight ops are discarded. No stale result appears after rst_n deasserts, even though the core pipeline still holds data.
- Arithmetic: the unit adds no rounding or exception handling; special values propagate as the core produces them.
- Elaboration checks: LAT>=1, FIFO_DEPTH>=1, DATA_W==32.

Decomposition:
- Package fpmul_stream_pkg:
  - DATA_W, default LAT and default FIFO_DEPTH constants.
  - typedef fp32_t (logic [31:0]).
  - typedef struct packed result_t {tag, data}, parametrised by TAG_W via package localparam default.
- Sub-module fpmul_result_fifo: synchronous FIFO of result_t with DEPTH, push/pop/flush, count, full/empty, and async active-low reset of pointers only.
- The top holds the core instance, shadow pipe, credit counter and overflow flag.

Test Plan:
- Single op: in_a=0x40000000, in_b=0x40400000, tag=3, out_ready=1 -> out_valid exactly LAT+1=6 cycles after accept, out_data=0x40C00000, out_tag=3.
- Sign case: 0x3FC00000 * 0xC0000000 -> out_data=0xC0400000; then 0x00000000 * 0x7F800000 -> the core's NaN pattern passed through unchanged.
- Streaming: 16 back-to-back ops with tags 0..15, out_ready=1 -> in_ready never drops, one result per cycle, tags emerge 0..15 in order, occupancy steady at 6.
- Backpressure: out_ready=0, in_valid held high -> exactly 8 accepts, in_ready=0, occupancy=8, out_data stable. Then out_ready=1 -> 8 results drain in order, in_ready reasserts the cycle after the first pop, overflow stays 0.
- Flush: 3 ops in flight plus 2 buffered, pulse flush -> next cycle out_valid=0, occupancy=0, and no results emerge in the following LAT+2 cycles.
- Async reset mid-op: rst_n low between clk edges with 4 ops in flight -> out_valid and in_ready go to 0 immediately. After release, in_ready=1 within 1 cycle and no stale outputs appear.

Source files
------------

// File: rtl/fpmul_stream_pkg.sv
// Shared constants and types for the streaming FP32 multiplier wrapper.
package fpmul_stream_pkg;
  localparam int FP_DATA_W      = 32;
  localparam int LAT_DEF        = 5;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int TAG_W_DEF      = 4;

  typedef logic [FP_DATA_W-1:0] fp32_t;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    fp32_t                data;
  } result_t;
endpackage

// File: rtl/FPmul.sv
// Fixed-latency IEEE-754 single multiplier: round-to-nearest-even, denormals flushed
// to zero on input and output, canonical quiet NaN 0x7FC00000. No stall or enable.
module FPmul
  import fpmul_stream_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic  clk,
  input  fp32_t FP_A,
  input  fp32_t FP_B,
  output fp32_t FP_Z
);
  logic              sa, sb, sz;
  logic [7:0]        ea, eb;
  logic [22:0]       ma, mb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       prod;
  logic [23:0]       sig;
  logic              rnd;
  logic [24:0]       sig_r;
  logic signed [9:0] exp_z;
  fp32_t             z_comb;
  logic [LAT*32-1:0] z_pipe;

  always_comb begin
    sa     = FP_A[31];
    ea     = FP_A[30:23];
    ma     = FP_A[22:0];
    sb     = FP_B[31];
    eb     = FP_B[30:23];
    mb     = FP_B[22:0];
    sz     = sa ^ sb;
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    b_nan  = (eb == 8'hFF) && (mb != 23'd0);
    prod   = {24'd0, 1'b1, ma} * {24'd0, 1'b1, mb};
    // Normalise the 48-bit product to 24 bits, keeping guard and sticky for RNE.
    if (prod[47]) begin
      sig = prod[47:24];
      rnd = prod[23] && ((|prod[22:0]) || prod[24]);
    end else begin
      sig = prod[46:23];
      rnd = prod[22] && ((|prod[21:0]) || prod[23]);
    end
    sig_r = {1'b0, sig} + {24'd0, rnd};
    exp_z = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
          + $signed({9'd0, prod[47]}) + $signed({9'd0, sig_r[24]});
    z_comb = {sz, exp_z[7:0], sig_r[24] ? sig_r[23:1] : sig_r[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      z_comb = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      z_comb = {sz, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      z_comb = {sz, 31'd0};
    end else if (exp_z > 10'sd254) begin
      z_comb = {sz, 8'hFF, 23'd0};
    end else if (exp_z < 10'sd1) begin
      z_comb = {sz, 31'd0};
    end
  end

  always_ff @(posedge clk) begin
    z_pipe <= (LAT*32)'({z_pipe, z_comb});
  end

  assign FP_Z = z_pipe[LAT*32-1 -: 32];
endmodule

// File: rtl/fpmul_result_fifo.sv
// Result FIFO with same-cycle push/pop, sync flush and async-reset pointers.
module fpmul_result_fifo
  import fpmul_stream_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  parameter int  W     = $bits(result_t),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fpmul_stream_unit.sv
// Valid/ready streaming wrapper around FPmul: shadow valid/tag pipe tracks each op,
// a credit counter guarantees the result FIFO always has room for every capture.
module fpmul_stream_unit
  import fpmul_stream_pkg::*;
#(
  parameter int  LAT        = LAT_DEF,
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int  TAG_W      = TAG_W_DEF,
  parameter int  DATA_W     = FP_DATA_W,
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [OCC_W-1:0]  occupancy,
  output logic              overflow
);
  if (LAT < 1 || FIFO_DEPTH < 1 || DATA_W != 32) begin : g_bad_params
    $error("fpmul_stream_unit: need LAT>=1, FIFO_DEPTH>=1, DATA_W==32");
  end

  logic                      ready_en, accept, pop, capture, fifo_empty, fifo_full;
  logic [OCC_W-1:0]          outstanding, fifo_count;
  logic [LAT-1:0]            sh_valid;
  logic [LAT*TAG_W-1:0]      sh_tag;
  logic [DATA_W-1:0]         core_z;
  logic [TAG_W+DATA_W-1:0]   head;

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_ready  = ready_en && (outstanding < OCC_W'(FIFO_DEPTH)) && !flush;
  assign capture   = sh_valid[LAT-1];
  assign fifo_full = (fifo_count == OCC_W'(FIFO_DEPTH));
  assign out_valid = !fifo_empty;
  assign {out_tag, out_data} = head;
  assign occupancy = outstanding;

  FPmul #(.LAT(LAT)) u_core (
    .clk  (clk),
    .FP_A (in_a),
    .FP_B (in_b),
    .FP_Z (core_z)
  );

  // Only the valids need reset: stale core data is harmless once its valid is gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid <= '0;
    end else if (flush) begin
      sh_valid <= '0;
    end else begin
      sh_valid <= LAT'({sh_valid, accept});
    end
  end

  always_ff @(posedge clk) begin
    sh_tag <= (LAT*TAG_W)'({sh_tag, in_tag});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      outstanding <= '0;
      overflow    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        outstanding <= '0;
      end else begin
        outstanding <= outstanding + OCC_W'(accept) - OCC_W'(pop);
      end
      if (!flush && capture && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  fpmul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TAG_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (capture),
    .pop   (pop),
    .wdata ({sh_tag[LAT*TAG_W-1 -: TAG_W], core_z}),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );
endmodule
